// File: rtl/cpu_mem_pkg.sv
// rtl/cpu_mem_pkg.sv - shared widths and clear-sequencer state encodings for the CPU data-memory port
package cpu_mem_pkg;

    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DONE  = 2'd2
    } clr_state_e;

endpackage

// File: rtl/ram_clear_sequencer.sv
// rtl/ram_clear_sequencer.sv - zero-fill sweep FSM driving the RAM write port while clearing
module ram_clear_sequencer
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = 4096
) (
    input  logic              clk,
    input  logic              resIn,
    input  logic              clr,
    output logic              busy,
    output logic              clr_done,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    // One extra counter bit so DEPTH == 2**ADDR_W reaches the terminal compare without wrapping.
    localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W + 1)'(DEPTH - 1);

    clr_state_e        state_q, state_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;

    // clr outranks resIn, so reset only applies when no clear request is present.
    always_ff @(posedge clk) begin
        if (resIn && !clr) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (clr) begin
            state_d = ST_CLEAR;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_IDLE;
                ST_CLEAR: begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // A sweep abandoned by resIn must not clear the word it was pointing at.
    always_comb begin
        busy     = (state_q == ST_CLEAR);
        clr_done = (state_q == ST_DONE);
        clr_we   = (state_q == ST_CLEAR) && !resIn;
        clr_addr = cnt_q[ADDR_W-1:0];
    end

endmodule

// File: rtl/data_ram_responder.sv
// rtl/data_ram_responder.sv - single-port data RAM answering CPU loads/stores with zero-fill and range flag
module data_ram_responder
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 4096
) (
    input  logic              clk,
    input  logic              resIn,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    input  logic              sel,
    input  logic              ld,
    input  logic              clr,
    output logic              busy,
    output logic              clr_done,
    output logic              range_err
);

    localparam int              MEM_AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic              in_range;
    logic              cpu_rd;
    logic              cpu_we;
    logic              seq_busy;
    logic              seq_we;
    logic [ADDR_W-1:0] seq_addr;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic              range_err_q, range_err_d;

    ram_clear_sequencer #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_seq (
        .clk      (clk),
        .resIn    (resIn),
        .clr      (clr),
        .busy     (seq_busy),
        .clr_done (clr_done),
        .clr_we   (seq_we),
        .clr_addr (seq_addr)
    );

    // A store coinciding with clr is dropped; resIn deliberately does not gate the array.
    always_comb begin
        in_range    = ({1'b0, addr} < DEPTH_W);
        cpu_rd      = sel && ld && !seq_busy && in_range;
        cpu_we      = sel && !ld && !seq_busy && in_range && !clr;
        range_err_d = sel && !seq_busy && !in_range && !clr;
        mem_we      = seq_we || cpu_we;
        mem_waddr   = seq_we ? seq_addr : addr;
        mem_wdata   = seq_we ? '0 : wdata;
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr[MEM_AW-1:0]] <= mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (resIn) begin
            range_err_q <= 1'b0;
        end else begin
            range_err_q <= range_err_d;
        end
    end

    always_comb begin
        rdata = '0;
        if (cpu_rd) begin
            rdata = mem[addr[MEM_AW-1:0]];
        end
    end

    assign busy      = seq_busy;
    assign range_err = range_err_q;

endmodule

// File: tb/tb_data_ram_responder.sv
// tb/tb_data_ram_responder.sv - randomized and directed checks of data_ram_responder against a word-array model
module tb_data_ram_responder;

    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        resIn;
    logic [11:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        sel, ld, clr;
    logic        busy, clr_done, range_err;

    always #5 clk = ~clk;

    data_ram_responder #(
        .ADDR_W (12),
        .DATA_W (16),
        .DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .resIn     (resIn),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .sel       (sel),
        .ld        (ld),
        .clr       (clr),
        .busy      (busy),
        .clr_done  (clr_done),
        .range_err (range_err)
    );

    logic [15:0] ram [DEPTH];
    int          sweep;
    logic        exp_done, exp_err;
    int          vectors, miscompares;
    logic [15:0] obs_rdata;
    logic        obs_busy, obs_done, obs_err;
    int          busy_cycles, done_at;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Model: sweep is the next word to clear, -1 when no sweep is running.
    task automatic cyc(input logic i_sel, input logic i_ld, input logic i_clr, input logic i_rst,
                       input logic [11:0] i_addr, input logic [15:0] i_wdata);
        logic [15:0] exp_rd;
        logic        busy_now;
        sel = i_sel; ld = i_ld; clr = i_clr; resIn = i_rst; addr = i_addr; wdata = i_wdata;
        @(negedge clk);
        busy_now = (sweep >= 0);
        exp_rd   = 16'h0000;
        if (i_sel && i_ld && !busy_now && i_addr < DEPTH) exp_rd = ram[i_addr[9:0]];
        obs_rdata = rdata; obs_busy = busy; obs_done = clr_done; obs_err = range_err;
        check("rdata", rdata, exp_rd);
        check("busy", busy, busy_now);
        check("clr_done", clr_done, exp_done);
        check("range_err", range_err, exp_err);
        @(posedge clk);
        exp_err = !i_rst && !i_clr && i_sel && !busy_now && (i_addr >= DEPTH);
        if (!busy_now && i_sel && !i_ld && !i_clr && i_addr < DEPTH) ram[i_addr[9:0]] = i_wdata;
        if (busy_now && !i_rst) ram[sweep] = 16'h0000;
        exp_done = 1'b0;
        if (i_clr) sweep = 0;
        else if (i_rst) sweep = -1;
        else if (busy_now) begin
            sweep++;
            if (sweep == DEPTH) begin
                sweep    = -1;
                exp_done = 1'b1;
            end
        end
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 16'h0000);
    endtask

    task automatic store(input logic [11:0] a, input logic [15:0] d);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, a, d);
    endtask

    task automatic load(input logic [11:0] a);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, a, 16'h0000);
    endtask

    // Runs random (ignored) accesses after a clr edge until clr_done, bounded.
    task automatic run_sweep();
        busy_cycles = 0;
        done_at     = -1;
        for (int k = 0; k < 2000 && done_at < 0; k++) begin
            cyc(1'b1, 1'($urandom), 1'b0, 1'b0, 12'($urandom_range(0, DEPTH - 1)), 16'($urandom));
            if (obs_busy) busy_cycles++;
            if (obs_done) done_at = k;
        end
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        sweep = -1; exp_done = 1'b0; exp_err = 1'b0;
        sel = 1'b0; ld = 1'b0; clr = 1'b0; resIn = 1'b1; addr = '0; wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 12'h000, 16'h0000);
        check("reset_busy", obs_busy, 1'b0);
        check("reset_done", obs_done, 1'b0);
        check("reset_err", obs_err, 1'b0);

        for (int a = 0; a < DEPTH; a++) store(12'(a), 16'($urandom));

        store(12'h010, 16'hBEEF);
        load(12'h010);
        check("beef_load", obs_rdata, 16'hBEEF);
        idle();
        check("rdata_no_sel", obs_rdata, 16'h0000);

        store(12'h400, 16'h1234);
        check("err_before", obs_err, 1'b0);
        idle();
        check("err_pulse", obs_err, 1'b1);
        idle();
        check("err_once", obs_err, 1'b0);
        load(12'h400);
        check("oor_load", obs_rdata, 16'h0000);
        load(12'h000);
        load(12'hFFF);
        idle();
        check("err_after_oor_load", obs_err, 1'b1);

        repeat (400) begin
            cyc(($urandom % 4) != 0, 1'($urandom), 1'b0, 1'b0,
                12'($urandom_range(0, 1299)), 16'($urandom));
        end

        for (int a = 0; a < 8; a++) store(12'(a), 16'(16'h0100 + a));
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 12'h005, 16'hDEAD);
        run_sweep();
        check("clr_busy_cycles", busy_cycles, DEPTH);
        check("clr_done_cycle", done_at, DEPTH);
        for (int a = 0; a < 8; a++) begin
            load(12'(a));
            check("cleared_word", obs_rdata, 16'h0000);
        end
        for (int a = 8; a < DEPTH; a++) load(12'(a));

        for (int a = 0; a < 200; a++) store(12'(a), 16'($urandom) | 16'h0001);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 12'h000, 16'h0000);
        repeat (100) idle();
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 12'h000, 16'h0000);
        run_sweep();
        check("restart_busy_cycles", busy_cycles, DEPTH);
        check("restart_done_cycle", done_at, DEPTH);

        for (int a = 0; a < 200; a++) store(12'(a), 16'(16'hA000 + a));
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 12'h000, 16'h0000);
        repeat (50) idle();
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 12'h000, 16'h0000);
        check("abort_busy_during", obs_busy, 1'b1);
        idle();
        check("abort_busy_after", obs_busy, 1'b0);
        check("abort_no_done", obs_done, 1'b0);
        load(12'd49);
        check("abort_word49", obs_rdata, 16'h0000);
        load(12'd50);
        check("abort_word50", obs_rdata, 16'hA032);
        load(12'd199);
        check("abort_word199", obs_rdata, 16'hA0C7);
        for (int a = 40; a < 70; a++) load(12'(a));

        cyc(1'b0, 1'b0, 1'b1, 1'b1, 12'h000, 16'h0000);
        run_sweep();
        check("rst_clr_busy_cycles", busy_cycles, DEPTH);
        check("rst_clr_done_cycle", done_at, DEPTH);

        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b1, 12'(12'h020 + i), 16'(16'h5A50 + i));
            check("rst_store_err", obs_err, 1'b0);
            check("rst_store_busy", obs_busy, 1'b0);
        end
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 12'h800, 16'h7777);
        idle();
        check("rst_oor_no_err", obs_err, 1'b0);
        for (int i = 0; i < 3; i++) begin
            load(12'(12'h020 + i));
            check("rst_store_landed", obs_rdata, 16'(16'h5A50 + i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
